// File: rtl/aes_block_ram_loader.sv
// Byte-serial loader that writes a 128-bit AES block into the 16 x 8 state/round-key RAM, MSB byte first.
// Optional readback check of the written bytes is enabled by defining AES_LOADER_READBACK_EN.
module aes_block_ram_loader #(
    parameter int NUM_BYTES  = 16,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_BYTES*BYTE_WIDTH-1:0] block_in,
    input  logic                            block_valid,
    output logic                            block_ready,
    output logic [BYTE_WIDTH-1:0]           ram_in,
    output logic [ADDR_WIDTH-1:0]           ram_address,
    output logic                            ram_enable,
    input  logic [BYTE_WIDTH-1:0]           ram_out,
    output logic                            busy,
    output logic                            done,
    output logic                            verify_error,
    output logic [1:0]                      dbg_state
);
    // Handshake: a block transfers on a rising edge where block_valid && block_ready;
    // block_ready is high only in IDLE and block_valid outside IDLE is simply ignored.
    localparam int BLOCK_W = NUM_BYTES * BYTE_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_BYTES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, VERIFY = 2'd2, DONE = 2'd3} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d, cnt_nx;
    logic [BLOCK_W-1:0]      blk_q, blk_d;
    logic [BYTE_WIDTH-1:0]   in_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic                    en_d, busy_d, done_d;

    // Byte 0 is the most significant byte of the block.
    function automatic logic [BYTE_WIDTH-1:0] byte_at(input logic [BLOCK_W-1:0] blk,
                                                      input logic [ADDR_WIDTH-1:0] idx);
        return blk[(NUM_BYTES - 1 - int'(idx)) * BYTE_WIDTH +: BYTE_WIDTH];
    endfunction

    assign cnt_nx      = cnt_q + ADDR_WIDTH'(1);
    assign block_ready = (state_q == IDLE);
    assign dbg_state   = state_q;

`ifdef AES_LOADER_READBACK_EN
    logic sticky_q, sticky_d, verr_q, verr_d, mismatch;
    assign mismatch     = (ram_out != byte_at(blk_q, cnt_q));
    assign verify_error = verr_q;
`else
    logic unused_ram_out;
    assign unused_ram_out = ^ram_out;
    assign verify_error   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        in_d    = ram_in;
        addr_d  = ram_address;
        en_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef AES_LOADER_READBACK_EN
        sticky_d = sticky_q;
        verr_d   = verr_q;
`endif
        case (state_q)
            IDLE: begin
                if (block_valid) begin
                    // Present byte 0 straight from block_in so the first write lands at T0+1.
                    blk_d   = block_in;
                    cnt_d   = '0;
                    state_d = WRITE;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    addr_d  = '0;
                    in_d    = byte_at(block_in, '0);
`ifdef AES_LOADER_READBACK_EN
                    sticky_d = 1'b0;
                    verr_d   = 1'b0;
`endif
                end
            end
            WRITE: begin
                busy_d = 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d = '0;
`ifdef AES_LOADER_READBACK_EN
                    state_d = VERIFY;
                    addr_d  = '0;
`else
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`endif
                end else begin
                    cnt_d  = cnt_nx;
                    addr_d = cnt_nx;
                    in_d   = byte_at(blk_q, cnt_nx);
                    en_d   = 1'b1;
                end
            end
`ifdef AES_LOADER_READBACK_EN
            VERIFY: begin
                busy_d   = 1'b1;
                sticky_d = sticky_q | mismatch;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    verr_d  = sticky_q | mismatch;
                end else begin
                    cnt_d  = cnt_nx;
                    addr_d = cnt_nx;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            blk_q       <= '0;
            ram_in      <= '0;
            ram_address <= '0;
            ram_enable  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef AES_LOADER_READBACK_EN
            sticky_q    <= 1'b0;
            verr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            blk_q       <= blk_d;
            ram_in      <= in_d;
            ram_address <= addr_d;
            ram_enable  <= en_d;
            busy        <= busy_d;
            done        <= done_d;
`ifdef AES_LOADER_READBACK_EN
            sticky_q    <= sticky_d;
            verr_q      <= verr_d;
`endif
        end
    end
endmodule

// File: tb/tb_aes_block_ram_loader.sv
// Scoreboard bench for aes_block_ram_loader: 16-byte instance plus a 4-byte instance,
// with a behavioural byte RAM whose read port can be corrupted at one address.
module tb_aes_block_ram_loader;
    localparam int NB = 16, BW = 8, AW = 4, BLK = NB * BW;
`ifdef AES_LOADER_READBACK_EN
    localparam int LAT = 33, LAT4 = 9, READBACK = 1;
`else
    localparam int LAT = 17, LAT4 = 5, READBACK = 0;
`endif
    localparam int PERIOD = LAT + 1;

    logic clk = 1'b0, rst = 1'b1;
    logic [BLK-1:0] block_in = '0;
    logic block_valid = 1'b0, block_ready, ram_enable, busy, done, verify_error;
    logic [BW-1:0] ram_in, ram_out;
    logic [AW-1:0] ram_address;
    logic [1:0] dbg_state;

    logic [31:0] block4_in = '0;
    logic block4_valid = 1'b0, block4_ready, ram4_enable, busy4, done4, verify4_error;
    logic [BW-1:0] ram4_in, ram4_out;
    logic [1:0] ram4_address, dbg4_state;

    logic [BW-1:0] mem [NB];
    logic [BW-1:0] mem4 [4];
    logic fault_en = 1'b0;
    logic [AW-1:0] fault_addr = '0;

    int cyc = 0, free = 0, last_t0 = 0, n_checks = 0, n_fail = 0;
    logic [43:0]  exp_q[$];        // {edge, addr, data}
    logic [160:0] exp_done_q[$];   // {edge, verify_error, ram image}
    logic [43:0]  exp4_q[$];
    logic [64:0]  exp4_done_q[$];

    aes_block_ram_loader dut (
        .clk(clk), .rst(rst), .block_in(block_in), .block_valid(block_valid),
        .block_ready(block_ready), .ram_in(ram_in), .ram_address(ram_address),
        .ram_enable(ram_enable), .ram_out(ram_out), .busy(busy), .done(done),
        .verify_error(verify_error), .dbg_state(dbg_state));

    aes_block_ram_loader #(.NUM_BYTES(4), .BYTE_WIDTH(8), .ADDR_WIDTH(2)) u4 (
        .clk(clk), .rst(rst), .block_in(block4_in), .block_valid(block4_valid),
        .block_ready(block4_ready), .ram_in(ram4_in), .ram_address(ram4_address),
        .ram_enable(ram4_enable), .ram_out(ram4_out), .busy(busy4), .done(done4),
        .verify_error(verify4_error), .dbg_state(dbg4_state));

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM models: synchronous byte write, combinational read
    always @(posedge clk) if (ram_enable) mem[ram_address] <= ram_in;
    always @(posedge clk) if (ram4_enable) mem4[ram4_address] <= ram4_in;
    assign ram_out  = (fault_en && ram_address == fault_addr) ? '0 : mem[ram_address];
    assign ram4_out = mem4[ram4_address];

    function automatic logic [BLK-1:0] mem_cat();
        logic [BLK-1:0] r = '0;
        for (int i = 0; i < NB; i++) r = {r[BLK-BW-1:0], mem[i]};
        return r;
    endfunction

    function automatic logic [31:0] mem4_cat();
        return {mem4[0], mem4[1], mem4[2], mem4[3]};
    endfunction

    task automatic check(input string nm, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // scoreboard monitors
    always @(negedge clk) begin
        if (rst) begin
            if (ram_enable) begin
                if (exp_q.size() == 0) check("unexpected_write", {1'b1, ram_address, ram_in}, '0);
                else check("write", {32'(cyc + 1), ram_address, ram_in}, exp_q.pop_front());
            end
            if (done) begin
                if (exp_done_q.size() == 0) check("unexpected_done", 1, 0);
                else check("done", {32'(cyc + 1), verify_error, mem_cat()}, exp_done_q.pop_front());
            end
            if (ram4_enable) begin
                if (exp4_q.size() == 0) check("unexpected_write4", {1'b1, ram4_address, ram4_in}, '0);
                else check("write4", {32'(cyc + 1), 2'b00, ram4_address, ram4_in}, exp4_q.pop_front());
            end
            if (done4) begin
                if (exp4_done_q.size() == 0) check("unexpected_done4", 1, 0);
                else check("done4", {32'(cyc + 1), verify4_error, mem4_cat()}, exp4_done_q.pop_front());
            end
        end
    end

    // driver: called just after a negedge; returns on the negedge following the handshake edge
    task automatic send(input logic [BLK-1:0] blk, input int nwr, input bit exp_err, input bit exp_done);
        int t0;
        t0 = (cyc + 1 > free) ? cyc + 1 : free;
        block_in = blk;
        block_valid = 1'b1;
        for (int i = 0; i < nwr; i++)
            exp_q.push_back({32'(t0 + 1 + i), 4'(i), blk[(NB - 1 - i) * BW +: BW]});
        if (exp_done) exp_done_q.push_back({32'(t0 + LAT), exp_err, blk});
        free = t0 + PERIOD;
        last_t0 = t0;
        while (cyc < t0) @(negedge clk);
        check("ready_low_in_write", block_ready, 0);
        check("busy_in_write", busy, 1);
    endtask

    task automatic idle();
        block_valid = 1'b0;
        while (cyc + 1 < free) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < NB; i++) mem[i] = '0;
        for (int i = 0; i < 4; i++) mem4[i] = '0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", block_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_enable", ram_enable, 0);
        check("rst_address", ram_address, 0);
        check("rst_ram_in", ram_in, 0);
        check("rst_verify_error", verify_error, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b1;
        free = cyc + 1;

        // single block
        send(128'h00112233445566778899aabbccddeeff, 16, 0, 1);
        idle();

        // valid held across two blocks: second handshake only at T0+18
        send(128'h0f0e0d0c0b0a09080706050403020100, 16, 0, 1);
        send({BLK{1'b1}}, 16, 0, 1);
        idle();

        // asynchronous reset while address 7 is being written
        send(128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf, 8, 0, 0);
        block_valid = 1'b0;
        while (cyc < last_t0 + 7) @(negedge clk);
        check("addr_before_reset", ram_address, 7);
        #2 rst = 1'b0;
        #1;
        check("async_rst_enable", ram_enable, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        free = cyc + 1;
        check("ready_after_reset", block_ready, 1);
        repeat (3) @(negedge clk);
        check("idle_after_reset", dbg_state, 0);

        // stray valid during WRITE is ignored
        send(128'h123456789abcdef0fedcba9876543210, 16, 0, 1);
        block_valid = 1'b0;
        while (cyc < last_t0 + 4) @(negedge clk);
        block_in = 128'hdeaddeaddeaddeaddeaddeaddeaddead;
        block_valid = 1'b1;
        @(negedge clk);
        idle();
        repeat (4) @(negedge clk);

        // corrupted readback at address 9 (flagged only with the readback build)
        fault_en = 1'b1;
        fault_addr = 4'd9;
        send(128'h0102030405060708090a0b0c0d0e0f10, 16, READBACK[0], 1);
        idle();
        fault_en = 1'b0;
        check("verify_error_held", verify_error, READBACK[0]);
        send(128'h00112233445566778899aabbccddeeff, 16, 0, 1);
        check("verify_error_cleared", verify_error, 0);
        idle();

        // 4-byte instance
        begin
            int t4;
            t4 = cyc + 1;
            block4_in = 32'hdeadbeef;
            block4_valid = 1'b1;
            exp4_q.push_back({32'(t4 + 1), 4'd0, 8'hde});
            exp4_q.push_back({32'(t4 + 2), 4'd1, 8'had});
            exp4_q.push_back({32'(t4 + 3), 4'd2, 8'hbe});
            exp4_q.push_back({32'(t4 + 4), 4'd3, 8'hef});
            exp4_done_q.push_back({32'(t4 + LAT4), 1'b0, 32'hdeadbeef});
            @(negedge clk);
            block4_valid = 1'b0;
            check("ready4_low", block4_ready, 0);
            repeat (LAT4 + 3) @(negedge clk);
            check("ready4_back", block4_ready, 1);
        end

        repeat (4) @(negedge clk);
        check("writes_drained", exp_q.size(), 0);
        check("dones_drained", exp_done_q.size(), 0);
        check("writes4_drained", exp4_q.size(), 0);
        check("dones4_drained", exp4_done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
